// File: rtl/adc_spi_captura_pkg.sv
// -----------------------------------------------------------------------------
// adc_spi_captura_pkg
// Shared constants for the SPI ADC capture front end:
//   - FSM state codes (3-bit, legacy-compatible numbering)
//   - default SCLK divider, frame length and result width
// -----------------------------------------------------------------------------
package adc_spi_captura_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_QUIET = 3'd4;

  // Defaults: 50 MHz clk_in / (2*25) = 1 MHz SCLK, 16-SCLK frame, 12-bit result
  localparam int SCLK_DIV_DEF   = 25;
  localparam int FRAME_BITS_DEF = 16;
  localparam int DATA_BITS_DEF  = 12;

  // Width of the SCLK period counter (must hold FRAME_BITS)
  localparam int BIT_CNT_W = 5;

endpackage

// File: rtl/adc_spi_captura_if.sv
// -----------------------------------------------------------------------------
// adc_spi_captura_if
// Three-wire SPI link between the capture block and the external ADC.
//   adc_cs_n  : chip select, active low (driven by the capture block)
//   adc_sclk  : serial clock, idles high (driven by the capture block)
//   adc_sdata : serial data from the ADC, MSB first
// Modports:
//   master : the capture block (drives cs_n/sclk, reads sdata)
//   slave  : the ADC side (reads cs_n/sclk, drives sdata)
// -----------------------------------------------------------------------------
interface adc_spi_captura_if;

  logic adc_cs_n;
  logic adc_sclk;
  logic adc_sdata;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    input  adc_sdata
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    output adc_sdata
  );

endinterface

// File: rtl/adc_spi_captura_sclk_div.sv
// -----------------------------------------------------------------------------
// adc_sclk_div
// SCLK half-period counter. Counts clk_in cycles 0..SCLK_DIV-1 and raises
// half_tick_o for the single cycle in which the count sits at SCLK_DIV-1, i.e.
// every SCLK_DIV cycles while clear_i is low. clear_i forces the count to 0
// and suppresses the tick, so the first tick after release comes exactly
// SCLK_DIV cycles after the last cleared cycle.
// Ports:
//   clk_in      : system clock
//   clk_rst_n   : asynchronous active-low reset
//   clear_i     : synchronous clear of the half-period count
//   half_tick_o : one-cycle strobe at the end of each half period
// -----------------------------------------------------------------------------
module adc_sclk_div #(
  parameter int SCLK_DIV = 25
) (
  input  logic clk_in,
  input  logic clk_rst_n,
  input  logic clear_i,
  output logic half_tick_o
);

  localparam int              CW   = $clog2(SCLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of a combinational block gets a default on entry so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d       = cnt_q;
    half_tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d       = '0;
      half_tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_in or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_spi_captura.sv
// -----------------------------------------------------------------------------
// adc_spi_captura
// Serial front end for a 12-bit SPI ADC (AD7476 class) reading the servo
// position pot. Each rising edge of sample_clk (a level from the rate counter
// in the clk_in domain) starts one FRAME_BITS-SCLK read frame; the leading
// FRAME_BITS-DATA_BITS bits are dropped and the result is presented on dato
// with a one-cycle dato_valid strobe.
//
// Frame sequence: IDLE -> START (tCS setup, SCLK_DIV cycles) -> SHIFT
// (FRAME_BITS periods of SCLK_DIV low + SCLK_DIV high) -> DONE (1 cycle,
// cs_n released) -> QUIET (SCLK_DIV cycles of CS-high time) -> IDLE.
//
// Ports:
//   clk_in, clk_rst_n : clock and asynchronous active-low reset
//   enable            : 1 = run, 0 = abort any frame and hold idle
//   sample_clk        : slow sample level; its rising edge requests a frame
//   adc               : SPI link (master modport): cs_n, sclk out, sdata in
//   dato              : last completed conversion
//   dato_valid        : one-cycle pulse when dato updates
//   busy              : high while a frame is in progress (START..QUIET)
//   overrun           : one-cycle pulse for a sample edge seen while busy
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module adc_spi_captura
  import adc_spi_captura_pkg::*;
#(
  parameter int SCLK_DIV   = SCLK_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk_in,
  input  logic                 clk_rst_n,
  input  logic                 enable,
  input  logic                 sample_clk,
  adc_spi_captura_if.master    adc,
  output logic [DATA_BITS-1:0] dato,
  output logic                 dato_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);

  logic                 sc_q;
  logic [2:0]           state_q, state_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  // Only the low DATA_BITS frame bits are kept: the leading bits shift out of
  // the top of this register and are never seen, whatever their value.
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] dato_q, dato_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;

  logic rise;
  logic div_clear;
  logic half_tick;

  // Rising-edge detect on the sample level; falling edges are ignored.
  assign rise = sample_clk & ~sc_q;

  // The divider is held at zero while idle, during the single DONE cycle and
  // while disabled, so START and QUIET each last exactly SCLK_DIV cycles.
  assign div_clear = !enable || (state_q == ST_IDLE) || (state_q == ST_DONE);

  adc_sclk_div #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_div (
    .clk_in      (clk_in),
    .clk_rst_n   (clk_rst_n),
    .clear_i     (div_clear),
    .half_tick_o (half_tick)
  );

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    commit_d  = 1'b0;
    dato_d    = dato_q;
    valid_d   = 1'b0;

    // A sample edge while a frame is running is reported and dropped. The
    // QUIET->IDLE cycle still counts as busy, so an edge there is an overrun.
    ovr_d = rise && enable && (state_q != ST_IDLE);

    // Result register is loaded one cycle after DONE released cs_n, so
    // dato_valid follows the cs_n rise by one cycle.
    if (commit_q && enable) begin
      dato_d  = shift_q;
      valid_d = 1'b1;
    end

    if (!enable) begin
      state_d   = ST_IDLE;
      cs_n_d    = 1'b1;
      sclk_d    = 1'b1;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cs_n_d    = 1'b1;
          sclk_d    = 1'b1;
          bit_cnt_d = '0;
          if (rise) begin
            state_d = ST_START;
            cs_n_d  = 1'b0;
          end
        end

        ST_START: begin
          if (half_tick) begin
            state_d = ST_SHIFT;
            sclk_d  = 1'b0;
          end
        end

        ST_SHIFT: begin
          if (half_tick) begin
            if (!sclk_q) begin
              // sclk 0->1: the ADC updated sdata on the previous fall, so the
              // bit is stable here.
              sclk_d    = 1'b1;
              shift_d   = {shift_q[DATA_BITS-2:0], adc.adc_sdata};
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end else if (bit_cnt_q == LAST_BIT) begin
              // End of the last high half: sclk stays high (its idle level).
              state_d = ST_DONE;
            end else begin
              sclk_d = 1'b0;
            end
          end
        end

        ST_DONE: begin
          cs_n_d   = 1'b1;
          commit_d = 1'b1;
          state_d  = ST_QUIET;
        end

        ST_QUIET: begin
          if (half_tick) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      sc_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      commit_q  <= 1'b0;
      dato_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sc_q      <= sample_clk;
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      commit_q  <= commit_d;
      dato_q    <= dato_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign adc.adc_cs_n = cs_n_q;
  assign adc.adc_sclk = sclk_q;
  assign dato         = dato_q;
  assign dato_valid   = valid_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_spi_captura.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_captura
// Self-checking bench for adc_spi_captura with SCLK_DIV=4. A behavioural ADC
// shifts a 16-bit word out on sclk falling edges while cs_n is low. The
// stimulus side predicts, from the frame timing rules, whether each sample
// edge starts a frame or is an overrun and queues the expected responses; a
// forked monitor compares DUT outputs against those queues every cycle.
// -----------------------------------------------------------------------------
module tb_adc_spi_captura;

  localparam int D       = 4;
  // Frame timing from the behavioural rules (cycles relative to start edge e0)
  localparam int T_VALID = 2 + 33 * D;            // dato_valid high
  localparam int T_CS    = 1 + 33 * D;            // cs_n low duration
  localparam int T_FRAME = D + 32 * D + 1 + D;    // START+SHIFT+DONE+QUIET

  typedef struct {
    int data;
    int due;
  } dexp_t;

  typedef struct {
    int start;
    int dur;
    int rises;   // -1: not checked
  } cexp_t;

  logic        clk_in;
  logic        clk_rst_n;
  logic        enable;
  logic        sample_clk;
  logic [11:0] dato;
  logic        dato_valid;
  logic        busy;
  logic        overrun;

  adc_spi_captura_if adc ();

  adc_spi_captura #(
    .SCLK_DIV   (D),
    .FRAME_BITS (16),
    .DATA_BITS  (12)
  ) dut (
    .clk_in     (clk_in),
    .clk_rst_n  (clk_rst_n),
    .enable     (enable),
    .sample_clk (sample_clk),
    .adc        (adc),
    .dato       (dato),
    .dato_valid (dato_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ADC model: next bit appears on each sclk fall while selected.
  logic [15:0] adc_word;
  logic [3:0]  idx = 4'd15;
  always @(negedge adc.adc_sclk or posedge adc.adc_cs_n) begin
    if (adc.adc_cs_n) begin
      idx <= 4'd15;
    end else begin
      adc.adc_sdata <= adc_word[idx];
      idx           <= idx - 4'd1;
    end
  end

  // Scoreboard and reference state
  dexp_t exp_data[$];
  int    exp_ovr[$];
  cexp_t exp_cs[$];
  int    frame_end  = -1;  // edge at which the running frame returns to IDLE
  int    busy_start = 0;
  int    busy_end   = -1;
  int    last_start = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Raise sample_clk at the current negedge; the next posedge is the edge e.
  task automatic fire(input logic [15:0] word, input int hold);
    int e;
    e = cyc + 1;
    if (enable) begin
      if (e <= frame_end) begin
        exp_ovr.push_back(e);
      end else begin
        adc_word = word;
        exp_data.push_back('{data: int'(word[11:0]), due: e + T_VALID});
        exp_cs.push_back('{start: e, dur: T_CS, rises: 16});
        last_start = e;
        frame_end  = e + T_FRAME;
        busy_start = e;
        busy_end   = e + T_FRAME - 1;
      end
    end
    sample_clk = 1'b1;
    repeat (hold) @(negedge clk_in);
    sample_clk = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic wait_until(input int target);
    while (cyc + 1 < target) @(negedge clk_in);
  endtask

  task automatic wait_idle();
    while (cyc < frame_end + 2) @(negedge clk_in);
  endtask

  task automatic monitor();
    logic  prev_cs, prev_sclk, exp_busy;
    int    low_cnt, rises, o;
    bit    in_frame, tracked;
    dexp_t d;
    cexp_t c;
    prev_cs = 1'b1; prev_sclk = 1'b1; in_frame = 1'b0; tracked = 1'b0;
    low_cnt = 0; rises = 0;
    forever begin
      @(negedge clk_in);
      if (!clk_rst_n) begin
        prev_cs = 1'b1; prev_sclk = 1'b1; in_frame = 1'b0;
      end else begin
        if (dato_valid) begin
          if (exp_data.size() == 0) check("spurious_valid", dato_valid, 0);
          else begin
            d = exp_data.pop_front();
            check("dato", dato, d.data);
            check("valid_cycle", cyc, d.due);
          end
        end
        if (overrun) begin
          if (exp_ovr.size() == 0) check("spurious_overrun", overrun, 0);
          else begin
            o = exp_ovr.pop_front();
            check("overrun_cycle", cyc, o);
          end
        end
        exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
        check("busy", busy, exp_busy);
        if (adc.adc_cs_n) check("sclk_idle_high", adc.adc_sclk, 1);

        if (prev_cs && !adc.adc_cs_n) begin
          in_frame = 1'b1; low_cnt = 1; rises = 0;
          tracked  = (exp_cs.size() != 0);
          if (!tracked) check("spurious_cs_fall", adc.adc_cs_n, 1);
          else check("cs_fall_cycle", cyc, exp_cs[0].start);
        end else if (in_frame && !adc.adc_cs_n) begin
          low_cnt++;
          if (!prev_sclk && adc.adc_sclk) rises++;
        end else if (in_frame) begin
          in_frame = 1'b0;
          if (tracked) begin
            c = exp_cs.pop_front();
            check("cs_low_cycles", low_cnt, c.dur);
            if (c.rises >= 0) check("sclk_rises", rises, c.rises);
          end
        end
        prev_cs   = adc.adc_cs_n;
        prev_sclk = adc.adc_sclk;
      end
    end
  endtask

  initial begin
    int a;
    clk_rst_n  = 1'b0;
    enable     = 1'b0;
    sample_clk = 1'b0;
    adc_word   = 16'h0000;
    fork monitor(); join_none

    // Reset with random inputs
    repeat (5) begin
      @(negedge clk_in);
      enable     = 1'($urandom_range(0, 1));
      sample_clk = 1'($urandom_range(0, 1));
    end
    check("rst_cs_n", adc.adc_cs_n, 1);
    check("rst_sclk", adc.adc_sclk, 1);
    check("rst_dato", dato, 0);
    check("rst_valid", dato_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    sample_clk = 1'b0;
    enable     = 1'b1;
    @(negedge clk_in);
    clk_rst_n = 1'b1;
    @(negedge clk_in);

    // Single frame and data extremes / leading-bit discard
    fire(16'h0A5C, 2); wait_idle();
    fire(16'h0FFF, 1); wait_idle();
    fire(16'h0000, 3); wait_idle();
    fire(16'hF123, 1); wait_idle();

    // Overrun at cycle 60 of a frame and at the QUIET->IDLE edge
    fire(16'h0A5C, 1);
    wait_until(last_start + 60);
    fire(16'hFFFF, 1);
    wait_until(frame_end);
    fire(16'hFFFF, 1);
    wait_idle();

    // Abort during the low half of SHIFT bit 7
    fire(16'h0777, 1);
    a = last_start + 13 * D + 2;
    wait_until(a);
    enable = 1'b0;
    void'(exp_data.pop_back());
    exp_cs[exp_cs.size() - 1].dur   = a - last_start;
    exp_cs[exp_cs.size() - 1].rises = -1;
    busy_end  = a - 1;
    frame_end = -1;
    @(negedge clk_in);
    check("abort_cs_n", adc.adc_cs_n, 1);
    check("abort_sclk", adc.adc_sclk, 1);
    fire(16'h0999, 1);             // ignored while disabled
    repeat (20) @(negedge clk_in);
    check("abort_dato_held", dato, 12'hA5C);
    enable = 1'b1;
    @(negedge clk_in);
    fire(16'h0BEE, 2); wait_idle();

    // Asynchronous reset in the middle of SHIFT
    fire(16'h0321, 1);
    wait_until(last_start + D + 20);
    @(posedge clk_in);
    #2 clk_rst_n = 1'b0;
    void'(exp_data.pop_back());
    void'(exp_cs.pop_back());
    frame_end = -1;
    busy_end  = -1;
    #1;
    check("arst_cs_n", adc.adc_cs_n, 1);
    check("arst_sclk", adc.adc_sclk, 1);
    check("arst_dato", dato, 0);
    check("arst_valid", dato_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    repeat (3) @(negedge clk_in);
    clk_rst_n = 1'b1;
    @(negedge clk_in);
    fire(16'h0CAB, 2); wait_idle();

    // Randomized edges: mix of clean frames and overruns
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 160)) @(negedge clk_in);
      fire(16'($urandom), $urandom_range(1, 4));
    end
    wait_idle();

    for (int i = 0; i < 3000 && (exp_data.size() + exp_ovr.size() + exp_cs.size()) != 0; i++)
      @(negedge clk_in);
    check("pending_valid", exp_data.size(), 0);
    check("pending_overrun", exp_ovr.size(), 0);
    check("pending_cs_frames", exp_cs.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
